// File: rtl/ureq_bridge_pkg.sv
// Shared types and helpers for the host <-> user-core FIFO bridge.
// Build option: UREQ_BRIDGE_TIMEOUT_EN enables the request watchdog.
package ureq_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_PUSH
    } state_t;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Error word: only the top bit of a DATA_W-wide word set (DATA_W <= 128).
    function automatic logic [127:0] err_word_wide(input int w);
        return 128'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/ureq_fifo_bridge_if.sv
// Host FIFO port and user-core request port of the bridge, bundled with modports.
interface ureq_fifo_bridge_if #(
    parameter int DATA_W = 32
);
    // Host side: wr_en pushes din unless full; rd_en pops unless empty, dout valid the next cycle.
    // Core side: core_req pulses once with core_cmd stable; busy rises, result sampled when it falls.
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              full;
    logic [DATA_W-1:0] dout;
    logic              rd_en;
    logic              empty;
    logic              core_req;
    logic [DATA_W-1:0] core_cmd;
    logic              core_busy;
    logic [DATA_W-1:0] core_rdata;

    modport slave (
        input  din, wr_en, rd_en, core_busy, core_rdata,
        output full, dout, empty, core_req, core_cmd
    );

    modport master (
        output din, wr_en, rd_en, core_busy, core_rdata,
        input  full, dout, empty, core_req, core_cmd
    );
endinterface

// File: rtl/ureq_sync_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
module ureq_sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (DEPTH_LOG2 + 1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/ureq_fifo_bridge.sv
// Host <-> user-core bridge: command FIFO, req/busy handshake FSM, result FIFO, optional auto-poll.
// Build option: UREQ_BRIDGE_TIMEOUT_EN adds a watchdog that pushes an error word on a hung core.
module ureq_fifo_bridge
    import ureq_bridge_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int POLL_CYC   = 0,
    parameter int TMO_CYC    = 65535
) (
    input  logic   clk,
    input  logic   rst_n,
    ureq_fifo_bridge_if.slave bus,
    output state_t state
);
    localparam int PCW = cnt_w(POLL_CYC);
    localparam logic [PCW-1:0] POLL_RELOAD = (POLL_CYC > 0) ? PCW'(POLL_CYC - 1) : '0;

    logic [DATA_W-1:0] cmd_rdata;
    logic              cmd_empty;
    logic              cmd_rd;
    logic              res_full;
    logic              res_wr;
    logic [DATA_W-1:0] rsp;
    logic              poll_sel;
    logic [PCW-1:0]    poll_cnt;
    logic              poll_due;
    logic              tmo_take;
    logic              stale;

    ureq_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (bus.din),
        .wr_en   (bus.wr_en),
        .rd_en   (cmd_rd),
        .rd_data (cmd_rdata),
        .full    (bus.full),
        .empty   (cmd_empty)
    );

    ureq_sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (rsp),
        .wr_en   (res_wr),
        .rd_en   (bus.rd_en),
        .rd_data (bus.dout),
        .full    (res_full),
        .empty   (bus.empty)
    );

    assign cmd_rd   = (state == ST_POP);
    assign res_wr   = (state == ST_PUSH);
    assign poll_due = (POLL_CYC > 0) && (poll_cnt == '0);

`ifdef UREQ_BRIDGE_TIMEOUT_EN
    localparam int TCW = cnt_w(TMO_CYC);
    localparam logic [TCW-1:0]    TMO_LIMIT = TCW'(TMO_CYC - 1);
    localparam logic [127:0]      ERR_WIDE  = err_word_wide(DATA_W);
    localparam logic [DATA_W-1:0] ERR_WORD  = ERR_WIDE[DATA_W-1:0];

    logic [TCW-1:0] wdog;
    logic           tmo_hit;

    assign tmo_hit  = (wdog == TMO_LIMIT);
    assign tmo_take = tmo_hit && (((state == ST_WAIT_ACK) && !bus.core_busy) ||
                                  ((state == ST_WAIT_DONE) && bus.core_busy));

    // An abandoned request may still finish later; hold off until busy is seen low in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog  <= '0;
            stale <= 1'b0;
        end else begin
            if ((state == ST_WAIT_ACK) || (state == ST_WAIT_DONE)) begin
                wdog <= wdog + 1'b1;
            end else begin
                wdog <= '0;
            end
            if (tmo_take) begin
                stale <= 1'b1;
            end else if ((state == ST_IDLE) && !bus.core_busy) begin
                stale <= 1'b0;
            end
        end
    end
`else
    assign tmo_take = 1'b0;
    assign stale    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bus.core_req <= 1'b0;
            bus.core_cmd <= '0;
            rsp          <= '0;
            poll_sel     <= 1'b0;
            poll_cnt     <= '0;
        end else begin
            bus.core_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((POLL_CYC > 0) && (poll_cnt != '0)) begin
                        poll_cnt <= poll_cnt - 1'b1;
                    end
                    // Host commands win; a due poll waits in IDLE until result space exists.
                    if (!stale && !res_full) begin
                        if (!cmd_empty) begin
                            poll_sel <= 1'b0;
                            state    <= ST_POP;
                        end else if (poll_due) begin
                            poll_sel <= 1'b1;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_POP: begin
                    state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    bus.core_cmd <= poll_sel ? '0 : cmd_rdata;
                    bus.core_req <= 1'b1;
                    poll_cnt     <= POLL_RELOAD;
                    state        <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (bus.core_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_take) begin
`ifdef UREQ_BRIDGE_TIMEOUT_EN
                        rsp <= ERR_WORD;
`endif
                        state <= ST_PUSH;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.core_busy) begin
                        rsp   <= bus.core_rdata;
                        state <= ST_PUSH;
                    end else if (tmo_take) begin
`ifdef UREQ_BRIDGE_TIMEOUT_EN
                        rsp <= ERR_WORD;
`endif
                        state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
